// File: rtl/uart_tx_periph.sv
// uart_tx_periph: 8N1 UART transmitter peripheral with a store buffer,
// sticky frame-done flag and a 32-bit status readback word.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1, 11-bit frame).
//
// state  | meaning
// -------+---------------------------------------------------
// IDLE   | line high, waiting for a start request
// START  | driving the start bit (0)
// DATA   | driving data bits, LSB first, bit_idx selects bit
// PARITY | driving even parity of the byte (parity build only)
// STOP   | driving the stop bit (1), sets done flag on exit
module uart_tx_periph #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable_StoreTxbuff,
   input  logic        Start_uart_tx,
   input  logic        clr_tx_flag,
   input  logic [31:0] WriteData,
   output logic        serial_tx,
   output logic        tx_busy,
   output logic        tx_done_flag,
   output logic [31:0] tx_status
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state, state_nxt;
   logic [15:0] baud_cnt, baud_nxt;
   logic [2:0]  bit_idx, idx_nxt;
   logic [7:0]  tx_buf, buf_nxt;
   logic [7:0]  shift_reg, shift_nxt;
   logic        ser_nxt;
   logic        done_nxt;
   logic        done_set;
   logic        bit_end;

   // Only the low byte of the store bus is meaningful.
   logic        unused_wdata;
   assign unused_wdata = ^WriteData[31:8];

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign tx_busy   = (state != IDLE);
   assign tx_status = {30'b0, tx_busy, tx_done_flag};

   // State, counters, buffers and the registered line driver.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         baud_cnt     <= 16'd0;
         bit_idx      <= 3'd0;
         tx_buf       <= 8'h00;
         shift_reg    <= 8'h00;
         serial_tx    <= 1'b1;
         tx_done_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         baud_cnt     <= baud_nxt;
         bit_idx      <= idx_nxt;
         tx_buf       <= buf_nxt;
         shift_reg    <= shift_nxt;
         serial_tx    <= ser_nxt;
         tx_done_flag <= done_nxt;
      end
   end

   // Next-state logic; serial_tx is computed one cycle early so the line
   // comes straight from a flop and changes exactly on state/bit entry.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + 16'd1;
      idx_nxt   = bit_idx;
      shift_nxt = shift_reg;
      ser_nxt   = serial_tx;
      done_set  = 1'b0;
      buf_nxt   = enable_StoreTxbuff ? WriteData[7:0] : tx_buf;

      case (state)
         IDLE: begin
            baud_nxt = 16'd0;
            ser_nxt  = 1'b1;
            if (Start_uart_tx) begin
               // tx_buf is the pre-edge value, so a same-edge store is
               // kept for the next frame rather than sent now.
               state_nxt = START;
               shift_nxt = tx_buf;
               idx_nxt   = 3'd0;
               ser_nxt   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               baud_nxt  = 16'd0;
               idx_nxt   = 3'd0;
               ser_nxt   = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_nxt = 16'd0;
               if (bit_idx == 3'd7) begin
                  idx_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
                  ser_nxt   = ^shift_reg;
`else
                  state_nxt = STOP;
                  ser_nxt   = 1'b1;
`endif
               end else begin
                  idx_nxt = bit_idx + 3'd1;
                  ser_nxt = shift_reg[bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               baud_nxt  = 16'd0;
               ser_nxt   = 1'b1;
            end
         end
`endif
         STOP: begin
            ser_nxt = 1'b1;
            if (bit_end) begin
               state_nxt = IDLE;
               baud_nxt  = 16'd0;
               done_set  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            baud_nxt  = 16'd0;
            ser_nxt   = 1'b1;
         end
      endcase

      // Completion beats a coincident clear.
      if (done_set)
         done_nxt = 1'b1;
      else if (!clr_tx_flag)
         done_nxt = 1'b0;
      else
         done_nxt = tx_done_flag;
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph at CLKS_PER_BIT=4. The reference
// model describes each frame as a list of line levels (start, data LSB
// first, optional parity, stop), each lasting CPB cycles, and tracks the
// buffered byte and done flag from the stimulus it applies.
module tb_uart_tx_periph;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        store;
   logic        start;
   logic        clr;
   logic [31:0] wdata;
   logic        serial_tx;
   logic        tx_busy;
   logic        tx_done_flag;
   logic [31:0] tx_status;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] model_buf;
   logic       model_done;

   typedef struct {
      logic [7:0] d;
      logic       par;
   } vec_t;

   vec_t vecs[6];

   uart_tx_periph #(.CLKS_PER_BIT(CPB)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable_StoreTxbuff(store),
      .Start_uart_tx     (start),
      .clr_tx_flag       (clr),
      .WriteData         (wdata),
      .serial_tx         (serial_tx),
      .tx_busy           (tx_busy),
      .tx_done_flag      (tx_done_flag),
      .tx_status         (tx_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input logic par, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == FL - 1) return 1'b1;
      return par;
   endfunction

   // store_mode: 0 = send current buffer, 1 = store store_d first,
   // 2 = store store_d on the same edge as start (buffer value is sent).
   // poke_cyc >= 0 asserts start and a store of poke_d mid-frame.
   task automatic run_frame(input int store_mode, input logic [7:0] store_d,
                            input logic exp_par, input int poke_cyc,
                            input logic [7:0] poke_d, input bit clr_at_end,
                            input string tag);
      logic [7:0] fd;
      int errs, busy_cnt, done_errs, idle_busy;
      errs = 0; busy_cnt = 0; done_errs = 0; idle_busy = 0;
      if (store_mode == 1) begin
         store = 1'b1;
         wdata = {8'($urandom), 16'($urandom), store_d};
         tick();
         store = 1'b0;
         model_buf = store_d;
      end
      fd = model_buf;
      start = 1'b1;
      if (store_mode == 2) begin
         store = 1'b1;
         wdata = {8'($urandom), 16'($urandom), store_d};
      end
      tick();
      start = 1'b0;
      store = 1'b0;
      if (store_mode == 2) model_buf = store_d;
      for (int s = 0; s < FL * CPB; s++) begin
         if (serial_tx !== frame_bit(fd, exp_par, s / CPB)) errs++;
         if (tx_busy === 1'b1) busy_cnt++;
         if (tx_done_flag !== model_done) done_errs++;
         start = 1'b0;
         store = 1'b0;
         clr   = 1'b1;
         if (s == poke_cyc) begin
            start = 1'b1;
            store = 1'b1;
            wdata = {8'($urandom), 16'($urandom), poke_d};
            model_buf = poke_d;
         end
         if (clr_at_end && s == FL * CPB - 1) clr = 1'b0;
         tick();
      end
      start = 1'b0;
      store = 1'b0;
      clr   = 1'b1;
      model_done = 1'b1;
      check({tag, "_serial_errs"}, 32'(errs), 32'd0);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FL * CPB));
      check({tag, "_done_hold_errs"}, 32'(done_errs), 32'd0);
      check({tag, "_end_busy"}, {31'b0, tx_busy}, 32'd0);
      check({tag, "_end_done"}, {31'b0, tx_done_flag}, 32'd1);
      check({tag, "_end_line"}, {31'b0, serial_tx}, 32'd1);
      check({tag, "_end_status"}, tx_status, 32'h1);
      for (int i = 0; i < 3 * CPB; i++) begin
         if (tx_busy !== 1'b0 || serial_tx !== 1'b1) idle_busy++;
         tick();
      end
      check({tag, "_no_queued_frame"}, 32'(idle_busy), 32'd0);
   endtask

   initial begin
      int rst_errs;
      logic [7:0] rd, pd;
      int pc;

      vecs[0] = '{d: 8'hA5, par: 1'b0};
      vecs[1] = '{d: 8'h07, par: 1'b1};
      vecs[2] = '{d: 8'hFF, par: 1'b0};
      vecs[3] = '{d: 8'h01, par: 1'b1};
      vecs[4] = '{d: 8'h80, par: 1'b1};
      vecs[5] = '{d: 8'h3C, par: 1'b0};

      reset = 1'b0; store = 1'b0; start = 1'b0; clr = 1'b1; wdata = 32'h0;
      model_buf = 8'h00; model_done = 1'b0;
      tick();
      // Reset must win over store/start requests.
      start = 1'b1; store = 1'b1; wdata = 32'h0000_00FF;
      tick();
      check("rst_line", {31'b0, serial_tx}, 32'd1);
      check("rst_busy", {31'b0, tx_busy}, 32'd0);
      check("rst_done", {31'b0, tx_done_flag}, 32'd0);
      check("rst_status", tx_status, 32'h0);
      reset = 1'b1; start = 1'b0; store = 1'b0;
      tick();
      check("post_rst_busy", {31'b0, tx_busy}, 32'd0);

      // Buffer is 0x00 out of reset.
      run_frame(0, 8'h00, 1'b0, -1, 8'h00, 1'b0, "rst_buf");

      for (int i = 0; i < 6; i++)
         run_frame(1, vecs[i].d, vecs[i].par, -1, 8'h00, 1'b0, $sformatf("vec%0d", i));

      // Start at cycle 10 and store 0xFF mid-frame: no effect on this frame.
      run_frame(1, 8'hA5, 1'b0, 10, 8'hFF, 1'b0, "midframe");
      run_frame(0, 8'h00, 1'b0, -1, 8'h00, 1'b0, "after_mid");

      // Clear with flag set.
      clr = 1'b0;
      tick();
      clr = 1'b1;
      model_done = 1'b0;
      check("clr_done", {31'b0, tx_done_flag}, 32'd0);
      tick();
      check("clr_hold", {31'b0, tx_done_flag}, 32'd0);

      // Clear coinciding with set: set wins.
      run_frame(1, 8'h3C, 1'b0, -1, 8'h00, 1'b1, "set_clr");
      tick();
      check("set_clr_hold", {31'b0, tx_done_flag}, 32'd1);

      // Store and start on the same edge: old byte (0x3C) goes out.
      run_frame(2, 8'h5A, 1'b0, -1, 8'h00, 1'b0, "same_edge");
      run_frame(0, 8'h00, 1'b0, -1, 8'h00, 1'b0, "buffered");

      for (int i = 0; i < 8; i++) begin
         rd = 8'($urandom);
         pd = 8'($urandom);
         pc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FL * CPB - 2)) : -1;
         run_frame(1, rd, ^rd, pc, pd, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      // Reset during DATA bit 3 of 0xA5 (done flag is set beforehand).
      store = 1'b1;
      wdata = 32'h0000_00A5;
      tick();
      store = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int s = 0; s < 4 * CPB + 1; s++) tick();
      check("abort_bit3_line", {31'b0, serial_tx}, 32'd0);
      check("abort_bit3_busy", {31'b0, tx_busy}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_done = 1'b0;
      model_buf = 8'h00;
      check("abort_line", {31'b0, serial_tx}, 32'd1);
      check("abort_busy", {31'b0, tx_busy}, 32'd0);
      check("abort_done", {31'b0, tx_done_flag}, 32'd0);
      rst_errs = 0;
      for (int i = 0; i < 12 * CPB; i++) begin
         if (tx_busy !== 1'b0 || tx_done_flag !== 1'b0 || serial_tx !== 1'b1) rst_errs++;
         tick();
      end
      check("abort_quiet_errs", 32'(rst_errs), 32'd0);
      run_frame(0, 8'h00, 1'b0, -1, 8'h00, 1'b0, "post_abort");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port enable_StoreTxbuff, input, 1, high = capture WriteData[7:0] into the TX buffer this edge.
REQ-005 The block SHALL have port Start_uart_tx, input, 1, high = request frame transmission.
REQ-006 The block SHALL have port clr_tx_flag, input, 1, active-low, 0 = clear tx_done_flag.
REQ-007 The block SHALL have port WriteData, input, 32, store data from the pipeline; only bits [7:0] are used.
REQ-008 The block SHALL have port serial_tx, output, 1, UART line, idle high.
REQ-009 The block SHALL have port tx_busy, output, 1, high while a frame is in progress.
REQ-010 The block SHALL have port tx_done_flag, output, 1, sticky frame-complete flag.
REQ-011 The block SHALL have port tx_status, output, 32, readback {30'b0, tx_busy, tx_done_flag}.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (only when configured), STOP.
REQ-013 A 16-bit baud counter SHALL count 0..CLKS_PER_BIT-1, restarting at 0 on every state entry; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-014 On enable_StoreTxbuff=1, the TX buffer SHALL load WriteData[7:0] at that edge, in any state.
REQ-015 In IDLE, Start_uart_tx=1 SHALL copy the TX buffer into the shift register and enter START; serial_tx=0 from the following cycle.
REQ-016 If store and start occur at the same edge, the frame SHALL carry the buffer value held before that edge; the new byte remains buffered.
REQ-017 START SHALL drive 0 for one bit time, then enter DATA.
REQ-018 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; after bit 7, go to PARITY if configured, else STOP.
REQ-019 STOP SHALL drive 1 for one bit time, then return to IDLE.
REQ-020 Start_uart_tx in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-021 A store during a frame SHALL NOT alter the frame in flight.
REQ-022 tx_busy SHALL be 1 in every state except IDLE; a frame SHALL hold tx_busy=1 for exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-023 tx_done_flag SHALL set on the edge at which STOP returns to IDLE.
REQ-024 tx_done_flag SHALL clear when clr_tx_flag=0, and SHALL otherwise hold.
REQ-025 If set and clear coincide, the set SHALL win.
REQ-026 Starting a new frame SHALL NOT clear tx_done_flag.
REQ-027 serial_tx SHALL be a registered output with no glitches.

Reset
REQ-028 When reset=0 at a rising edge: FSM = IDLE, baud counter = 0, bit index = 0, TX buffer = 0x00, shift register = 0x00, serial_tx = 1, tx_busy = 0, tx_done_flag = 0.
REQ-029 Reset SHALL abort a frame mid-transmission, with serial_tx=1 from the cycle after the reset edge; no done flag SHALL be set for the aborted frame.
REQ-030 Reset SHALL take priority over every other input.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be compiled in; it sends an even-parity bit (XOR of the 8 data bits) for one bit time between DATA and STOP (11-bit frame).
REQ-032 Without UART_TX_PARITY_EN, there SHALL be no PARITY state or parity logic; DATA goes directly to STOP (10-bit frame).

Verification (CLKS_PER_BIT=4)
REQ-033 Store 0x000000A5, then pulse start -> serial_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high for 40 cycles; tx_done_flag=1 on return to IDLE.
REQ-034 Same stimulus with UART_TX_PARITY_EN; also store 0x07 -> for 0xA5, parity bit 0 after bit 7 and tx_busy high for 44 cycles; for 0x07, parity bit 1.
REQ-035 Pulse start at cycle 10 of a frame, and store 0xFF mid-frame -> frame unchanged, no second frame; the next start transmits 0xFF.
REQ-036 Hold clr_tx_flag=0 for 1 cycle with the flag set -> tx_done_flag=0; hold clr_tx_flag=0 on the cycle the flag sets -> tx_done_flag=1.
REQ-037 Assert reset=0 for 1 cycle during DATA bit 3 -> serial_tx=1, tx_busy=0, tx_done_flag=0 the next cycle; no frame completes.
